// File: rtl/systolic_matmul_engine.sv
// Output-stationary ROWSxCOLS systolic MAC array with operand skew and job FSM.
// Define SYSTOLIC_SIGNED_EN for two's-complement operands; unsigned otherwise.
module systolic_matmul_engine #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 16
) (
    input  logic                                      i_clk,
    input  logic                                      i_arst,
    input  logic                                      i_start,
    input  logic [$clog2(K_MAX+1)-1:0]                i_kLen,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [ROWS-1:0][DATA_W-1:0]               i_aVec,
    input  logic [COLS-1:0][DATA_W-1:0]               i_bVec,
    output logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]      o_c,
    output logic                                      o_cValid,
    input  logic                                      i_cAck,
    output logic                                      o_busy
);

    localparam int KW = $clog2(K_MAX+1);
    localparam int FW = $clog2(ROWS+COLS);
    localparam int PW = 2*DATA_W;
    localparam logic [FW-1:0] FLAST = FW'(ROWS+COLS-2);

    typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] klen_q, klen_d;
    logic [KW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          accept, clr, mac_en;

    logic [DATA_W-1:0] a_op [ROWS][COLS];
    logic [DATA_W-1:0] b_op [ROWS][COLS];

    function automatic logic [ACC_W-1:0] prod(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [PW-1:0] p;
`ifdef SYSTOLIC_SIGNED_EN
        p = PW'($signed(a)) * PW'($signed(b));
        return ACC_W'($signed(p));
`else
        p = PW'(a) * PW'(b);
        return ACC_W'(p);
`endif
    endfunction

    assign o_ready  = (state_q == STREAM);
    assign o_cValid = (state_q == DONE);
    assign o_busy   = (state_q != IDLE);
    assign accept   = i_valid && o_ready;
    assign clr      = (state_q == IDLE) && i_start;
    assign mac_en   = (state_q == STREAM) || (state_q == FLUSH);
    assign cnt_inc  = cnt_q + KW'(1);

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= IDLE;
            klen_q  <= '0;
            cnt_q   <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            klen_q  <= klen_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        klen_d  = klen_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    klen_d  = i_kLen;
                    cnt_d   = '0;
                    fcnt_d  = '0;
                    state_d = (i_kLen == '0) ? DONE : STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == klen_q) begin
                        state_d = FLUSH;
                        fcnt_d  = '0;
                    end
                end
            end
            FLUSH: begin
                if (fcnt_q == FLAST) begin
                    state_d = DONE;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
            DONE: begin
                if (i_cAck) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row i of A passes through i+1 registers, so it reaches PE[i][0] i cycles late.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic [DATA_W-1:0] sk [i+1];
        always_ff @(posedge i_clk or posedge i_arst) begin
            if (i_arst || clr) begin
                for (int d = 0; d <= i; d++) sk[d] <= '0;
            end else begin
                sk[0] <= accept ? i_aVec[i] : '0;
                for (int d = 1; d <= i; d++) sk[d] <= sk[d-1];
            end
        end
        assign a_op[i][0] = sk[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic [DATA_W-1:0] sk [j+1];
        always_ff @(posedge i_clk or posedge i_arst) begin
            if (i_arst || clr) begin
                for (int d = 0; d <= j; d++) sk[d] <= '0;
            end else begin
                sk[0] <= accept ? i_bVec[j] : '0;
                for (int d = 1; d <= j; d++) sk[d] <= sk[d-1];
            end
        end
        assign b_op[0][j] = sk[j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            logic [ACC_W-1:0] acc;

            always_ff @(posedge i_clk or posedge i_arst) begin
                if (i_arst || clr) begin
                    acc <= '0;
                end else if (mac_en) begin
                    acc <= acc + prod(a_op[i][j], b_op[i][j]);
                end
            end
            assign o_c[i][j] = acc;

            if (j < COLS-1) begin : g_af
                logic [DATA_W-1:0] a_q;
                always_ff @(posedge i_clk or posedge i_arst) begin
                    if (i_arst || clr) a_q <= '0;
                    else               a_q <= a_op[i][j];
                end
                assign a_op[i][j+1] = a_q;
            end

            if (i < ROWS-1) begin : g_bf
                logic [DATA_W-1:0] b_q;
                always_ff @(posedge i_clk or posedge i_arst) begin
                    if (i_arst || clr) b_q <= '0;
                    else               b_q <= b_op[i][j];
                end
                assign b_op[i+1][j] = b_q;
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Randomised and directed bench for systolic_matmul_engine (4x4, 8-bit, 32-bit acc).
// Matrix-level reference model plus per-cycle compare of handshake and results.
module tb_systolic_matmul_engine;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int KM = 16;
    localparam int KW = 5;
    localparam int FL = R + C - 1;
`ifdef SYSTOLIC_SIGNED_EN
    localparam logic [AW-1:0] T4_EXP = 32'd16;
`else
    localparam logic [AW-1:0] T4_EXP = 32'd1040400;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic valid = 1'b0;
    logic ack = 1'b0;
    logic ready, cvalid, busy;
    logic [KW-1:0] klen = '0;
    logic [R-1:0][DW-1:0] avec = '0;
    logic [C-1:0][DW-1:0] bvec = '0;
    logic [R-1:0][C-1:0][AW-1:0] oc;
    logic [R-1:0][C-1:0][AW-1:0] cap;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rdy_cnt = 0;
    int acc_cyc = 0;
    int lat = -1;
    bit en_chk = 1'b0;

    logic [DW-1:0] ja [KM][R];
    logic [DW-1:0] jb [KM][C];

    systolic_matmul_engine #(
        .ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW), .K_MAX(KM)
    ) dut (
        .i_clk(clk), .i_arst(rst), .i_start(start), .i_kLen(klen),
        .i_valid(valid), .o_ready(ready), .i_aVec(avec), .i_bVec(bvec),
        .o_c(oc), .o_cValid(cvalid), .i_cAck(ack), .o_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [AW-1:0] prod(input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
`ifdef SYSTOLIC_SIGNED_EN
        return AW'($signed(a)) * AW'($signed(b));
`else
        return AW'(a) * AW'(b);
`endif
    endfunction

    // Reference: 0 idle, 1 streaming, 2 flushing, 3 result held.
    int m_st = 0;
    int m_klen = 0;
    int m_beats = 0;
    int m_fl = 0;
    logic [AW-1:0] m_c [R][C];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st <= 0; m_klen <= 0; m_beats <= 0; m_fl <= 0;
            for (int i = 0; i < R; i++)
                for (int j = 0; j < C; j++) m_c[i][j] <= '0;
        end else begin
            case (m_st)
                0: if (start) begin
                    for (int i = 0; i < R; i++)
                        for (int j = 0; j < C; j++) m_c[i][j] <= '0;
                    m_klen <= int'(klen);
                    m_beats <= 0;
                    m_st <= (klen == '0) ? 3 : 1;
                end
                1: if (valid) begin
                    for (int i = 0; i < R; i++)
                        for (int j = 0; j < C; j++)
                            m_c[i][j] <= m_c[i][j] + prod(avec[i], bvec[j]);
                    m_beats <= m_beats + 1;
                    if (m_beats + 1 == m_klen) begin
                        m_st <= 2;
                        m_fl <= 0;
                    end
                end
                2: begin
                    m_fl <= m_fl + 1;
                    if (m_fl + 1 == FL) m_st <= 3;
                end
                3: if (ack) m_st <= 0;
                default: m_st <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (en_chk) begin
            check("ready", ready, m_st == 1);
            check("busy", busy, m_st != 0);
            check("cvalid", cvalid, m_st == 3);
            if (m_st == 3 || rst || (m_st == 1 && m_beats == 0)) begin
                for (int i = 0; i < R; i++)
                    for (int j = 0; j < C; j++)
                        check($sformatf("c[%0d][%0d]", i, j),
                              oc[i][j], m_c[i][j]);
            end
            if (ready) rdy_cnt++;
        end
    end

    // vmode: 0 valid held, 1 toggled, 2 random; dmode: 0 random, 1 all FF, 2 identity/3.
    task automatic do_job(input int k, input int vmode, input int dmode,
                          input bit dual);
        int beat;
        int n;
        for (int kk = 0; kk < KM; kk++) begin
            for (int i = 0; i < R; i++)
                ja[kk][i] = (dmode == 1) ? 8'hFF :
                            (dmode == 2) ? ((i == kk) ? 8'd1 : 8'd0) :
                            DW'($urandom);
            for (int j = 0; j < C; j++)
                jb[kk][j] = (dmode == 1) ? 8'hFF :
                            (dmode == 2) ? 8'd3 : DW'($urandom);
        end
        start = 1'b1;
        klen = KW'(k);
        valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        rdy_cnt = 0;
        acc_cyc = cyc;
        beat = 0;
        n = 0;
        while (beat < k && n < 500) begin
            valid = (vmode == 0) ? 1'b1 :
                    (vmode == 1) ? ((n % 2) == 0) :
                    ($urandom_range(0, 3) != 0);
            for (int i = 0; i < R; i++) avec[i] = ja[beat][i];
            for (int j = 0; j < C; j++) bvec[j] = jb[beat][j];
            ack = (vmode == 2) && ($urandom_range(0, 7) == 0);
            start = (vmode == 2) && ($urandom_range(0, 7) == 0);
            @(negedge clk);
            if (valid && ready) begin
                beat++;
                acc_cyc = cyc + 1;
            end
            @(posedge clk); #1;
            n++;
        end
        ack = 1'b0;
        start = 1'b0;
        if (beat < k) check("beat_timeout", beat, k);
        lat = -1;
        for (int w = 0; w < 100 && lat < 0; w++) begin
            valid = (vmode == 2) && ($urandom_range(0, 1) == 0);
            start = (vmode == 2) && ($urandom_range(0, 3) == 0);
            avec = R*DW'($urandom);
            bvec = C*DW'($urandom);
            @(negedge clk);
            if (cvalid) begin
                lat = cyc - acc_cyc;
                cap = oc;
            end else begin
                @(posedge clk); #1;
            end
        end
        valid = 1'b0;
        start = 1'b0;
        if (lat < 0) check("cvalid_timeout", cvalid, 1);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(posedge clk); #1;
        ack = 1'b1;
        start = dual;
        if (dual) klen = KW'($urandom_range(1, KM));
        @(posedge clk); #1;
        ack = 1'b0;
        start = 1'b0;
        if (dual) begin
            @(negedge clk);
            check("dual_idle_busy", busy, 0);
            check("dual_idle_ready", ready, 0);
        end
    endtask

    task automatic check_cap(input string nm, input logic [AW-1:0] exp);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++)
                check($sformatf("%s[%0d][%0d]", nm, i, j), cap[i][j], exp);
    endtask

    initial begin
        @(posedge clk); #1;
        en_chk = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        do_job(4, 0, 2, 1'b0);
        check("t1_ready_cycles", rdy_cnt, 4);
        check("t1_latency", lat, FL);
        check_cap("t1_c", 32'd3);

        do_job(4, 1, 2, 1'b0);
        check("t2_latency", lat, FL);
        check_cap("t2_c", 32'd3);

        do_job(0, 0, 0, 1'b0);
        check("t3_latency", lat, 0);
        check_cap("t3_c", 32'd0);
        check("t3_idle", busy, 0);

        do_job(16, 0, 1, 1'b0);
        check("t4_latency", lat, FL);
        check_cap("t4_c", T4_EXP);

        start = 1'b1;
        klen = KW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        valid = 1'b1;
        avec = R*DW'($urandom);
        bvec = C*DW'($urandom);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_ready", ready, 0);
        check("t5_busy", busy, 0);
        check("t5_c_any", |oc, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        valid = 1'b0;
        @(posedge clk); #1;
        do_job(4, 0, 2, 1'b0);
        check_cap("t5_fresh_c", 32'd3);

        do_job(4, 2, 0, 1'b1);
        do_job(4, 0, 2, 1'b0);
        check_cap("t6_next_c", 32'd3);

        repeat (20) begin
            do_job($urandom_range(1, KM), 2, 0, ($urandom_range(0, 3) == 0));
            check("rand_latency", lat, FL);
        end

        @(posedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
